// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outbound valid/ready stream of fifo_stream_reader.
// "master" is the reader side; "slave" is the FIFO/sink side.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 16
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_r_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             burst_done;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data, m_last, burst_done
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data, m_last, burst_done
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO into a 2-entry skid buffer and presents the words
// as a valid/ready stream framed into bursts of BURST_LEN beats.
module fifo_stream_reader #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    fifo_stream_reader_if.master bus
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [1:0]       occ;
    logic             inflight;
    logic [CW-1:0]    beat_cnt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             burst_done_q;

    logic             pop;
    logic             last_beat;
    logic [2:0]       level;
    logic [1:0]       remain;
    logic             r_en;

    assign pop       = bus.m_valid & bus.m_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Words held or owed to the buffer once this cycle's pop is taken out.
    assign level  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign remain = occ - {1'b0, pop};
    assign r_en   = rstn & ~clr & ~bus.fifo_empty & (level < 3'd2);

    assign bus.fifo_r_en  = r_en;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = head;
    assign bus.m_last     = bus.m_valid & last_beat;
    assign bus.burst_done = burst_done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ          <= 2'd0;
            inflight     <= 1'b0;
            beat_cnt     <= '0;
            head         <= '0;
            tail         <= '0;
            burst_done_q <= 1'b0;
        end else if (clr) begin
            occ          <= 2'd0;
            inflight     <= 1'b0;
            beat_cnt     <= '0;
            burst_done_q <= 1'b0;
        end else begin
            inflight     <= r_en;
            occ          <= level[1:0];
            burst_done_q <= pop & last_beat;
            if (pop) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
            end
            if (pop && (occ == 2'd2)) begin
                head <= tail;
            end
            // Returning word lands behind whatever survives this cycle's pop.
            if (inflight) begin
                if (remain == 2'd0) begin
                    head <= bus.fifo_data;
                end else begin
                    tail <= bus.fifo_data;
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

endmodule
